// File: rtl/fifo_sync_ext_if.sv
// fifo_sync_ext_if: producer/consumer handshake bundle for fifo_sync_ext
interface fifo_sync_ext_if #(parameter int AW = 4, parameter int DW = 8);
   logic          wen;
   logic [DW-1:0] din;
   logic          ren;
   logic          clr_err;
   logic [DW-1:0] dout;
   logic          dvalid;
   logic [AW:0]   cnt;
   logic          wfull;
   logic          rempty;
   logic          afull;
   logic          aempty;
   logic          ovf;
   logic          udf;
   modport master(
      output wen, din, ren, clr_err,
      input  dout, dvalid, cnt, wfull, rempty, afull, aempty, ovf, udf
   );
   modport slave(
      input  wen, din, ren, clr_err,
      output dout, dvalid, cnt, wfull, rempty, afull, aempty, ovf, udf
   );
endinterface

// File: rtl/fifo_sync_ext.sv
// fifo_sync_ext: single-clock FIFO with FWFT option, thresholds, sticky errors
module fifo_sync_ext #(
   parameter int AW    = 4,
   parameter int DW    = 8,
   parameter int FWFT  = 0,
   parameter int AF_TH = 14,
   parameter int AE_TH = 2
) (
   input logic            clk,
   input logic            rst,
   fifo_sync_ext_if.slave bus
);
   logic [DW-1:0] ram [1<<AW];
   logic [AW-1:0] waddr, raddr;
   logic [AW:0]   cnt;
   logic [DW-1:0] q;
   logic          dv, ovf, udf, rempty, wfull, rd_ok, wr_ok;
   always_comb begin
      rempty = cnt == '0;
      wfull  = cnt[AW];
      rd_ok  = bus.ren & ~rempty;
      wr_ok  = bus.wen & (~wfull | rd_ok);
   end
   always_ff @(posedge clk)
      if (wr_ok) ram[waddr] <= bus.din;
   // q is the popped word in standard mode, the last shown word in FWFT mode
   always_ff @(posedge clk)
      if (rst) begin
         waddr <= '0;
         raddr <= '0;
         cnt   <= '0;
         q     <= '0;
         dv    <= 1'b0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         waddr <= waddr + AW'(wr_ok);
         raddr <= raddr + AW'(rd_ok);
         cnt   <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
         q     <= ((FWFT != 0) ? ~rempty : rd_ok) ? ram[raddr] : q;
         dv    <= rd_ok;
         ovf   <= (bus.wen & ~wr_ok) | (ovf & ~bus.clr_err);
         udf   <= (bus.ren & rempty) | (udf & ~bus.clr_err);
      end
   assign bus.dout   = ((FWFT != 0) && !rempty) ? ram[raddr] : q;
   assign bus.dvalid = (FWFT != 0) ? ~rempty : dv;
   assign bus.cnt    = cnt;
   assign bus.wfull  = wfull;
   assign bus.rempty = rempty;
   assign bus.afull  = cnt >= (AW+1)'(AF_TH);
   assign bus.aempty = cnt <= (AW+1)'(AE_TH);
   assign bus.ovf    = ovf;
   assign bus.udf    = udf;
endmodule
